serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 146 ++++++++++++++
 tb/tb_serial_subtractor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor D = A - B - B_in, LSB first, with a start/busy/done handshake.
// Optional signed-overflow output V is built when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             B_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             B_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             V
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_nx;
    logic [WIDTH-1:0] a_q, a_nx;
    logic [WIDTH-1:0] b_q, b_nx;
    logic [WIDTH-1:0] res_q, res_nx;
    logic             br_q, br_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic             busy_nx, done_nx, b_out_nx;
    logic [WIDTH-1:0] d_nx;

    // Full subtractor built from two cascaded half-subtractor stages
    logic hs1_diff_c, hs1_borrow_c, hs2_diff_c, hs2_borrow_c;
    assign hs1_diff_c   = a_q[0] ^ b_q[0];
    assign hs1_borrow_c = ~a_q[0] & b_q[0];
    assign hs2_diff_c   = hs1_diff_c ^ br_q;
    assign hs2_borrow_c = ~hs1_diff_c & br_q;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_q, a_msb_nx;
    logic b_msb_q, b_msb_nx;
    logic v_nx;
`endif

    // Next-state and datapath update
    always_comb begin
        state_nx = state_q;
        a_nx     = a_q;
        b_nx     = b_q;
        res_nx   = res_q;
        br_nx    = br_q;
        cnt_nx   = cnt_q;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        d_nx     = D;
        b_out_nx = B_out;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_nx = a_msb_q;
        b_msb_nx = b_msb_q;
        v_nx     = V;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_nx     = A;
                    b_nx     = B;
                    br_nx    = B_in;
                    res_nx   = '0;
                    cnt_nx   = '0;
                    busy_nx  = 1'b1;
                    state_nx = S_RUN;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_nx = A[WIDTH-1];
                    b_msb_nx = B[WIDTH-1];
`endif
                end
            end
            S_RUN: begin
                res_nx = {hs2_diff_c, res_q[WIDTH-1:1]};
                a_nx   = a_q >> 1;
                b_nx   = b_q >> 1;
                br_nx  = hs1_borrow_c | hs2_borrow_c;
                cnt_nx = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_nx = S_DONE;
                end else begin
                    busy_nx = 1'b1;
                end
            end
            S_DONE: begin
                d_nx     = res_q;
                b_out_nx = br_q;
                done_nx  = 1'b1;
                state_nx = S_IDLE;
`ifdef SERIAL_SUB_OVF_EN
                v_nx = (a_msb_q ^ b_msb_q) & (a_msb_q ^ res_q[WIDTH-1]);
`endif
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            D       <= '0;
            B_out   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            V       <= 1'b0;
`endif
        end else begin
            state_q <= state_nx;
            a_q     <= a_nx;
            b_q     <= b_nx;
            res_q   <= res_nx;
            br_q    <= br_nx;
            cnt_q   <= cnt_nx;
            busy    <= busy_nx;
            done    <= done_nx;
            D       <= d_nx;
            B_out   <= b_out_nx;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= a_msb_nx;
            b_msb_q <= b_msb_nx;
            V       <= v_nx;
`endif
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): stimulus pushes expected results, a monitor pops on done.
module tb_serial_subtractor;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] A, B;
    logic             B_in;
    logic             busy, done;
    logic [WIDTH-1:0] D;
    logic             B_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             V;
`endif

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .B_in  (B_in),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .B_out (B_out)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .V     (V)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             bo;
        logic             v;
        int               due;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare on every done pulse; flag overdue or unexpected results
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1, expected 0 with no op pending (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("D", 32'(D), 32'(e.d));
                    check("B_out", 32'(B_out), 32'(e.bo));
`ifdef SERIAL_SUB_OVF_EN
                    check("V", 32'(V), 32'(e.v));
`endif
                    check("done_cycle", 32'(cyc), 32'(e.due));
                    check("busy_with_done", 32'(busy), 32'(0));
                end
            end else if (sb.size() != 0 && cyc > sb[0].due) begin
                e = sb.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL done_missing: got no done by cycle %0d, expected at cycle %0d", cyc, e.due);
            end
        end
    end

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                         input logic [WIDTH-1:0] ed, input logic ebo, input logic ev);
        int acc;
        @(negedge clk);
        A = a; B = b; B_in = bin; start = 1'b1;
        @(posedge clk);
        acc = cyc;
        sb.push_back('{ed, ebo, ev, acc + int'(WIDTH) + 2});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected end before 100000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; B_in = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        check("reset_D", 32'(D), 32'(0));
        check("reset_B_out", 32'(B_out), 32'(0));
`ifdef SERIAL_SUB_OVF_EN
        check("reset_V", 32'(V), 32'(0));
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // 1: basic subtraction, latency checked by monitor
        issue(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
        check("busy_after_accept", 32'(busy), 32'(1));
        wait_idle();
        check("busy_idle", 32'(busy), 32'(0));
        check("D_hold_1", 32'(D), 32'(8'h1E));

        // 2: underflow wraps
        issue(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        wait_idle();

        // 3: signed overflow both directions
        issue(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        wait_idle();
        issue(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        wait_idle();

        // 4: borrow-in, operands changed right after capture
        issue(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0);
        A = 8'hFF; B = 8'h00; B_in = 1'b0;
        wait_idle();

        // 5a: stray start pulses during RUN and DONE are dropped
        issue(8'h22, 8'h11, 1'b0, 8'h11, 1'b0, 1'b0);
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (12) @(negedge clk);

        // 5b: reset during the 4th RUN cycle aborts the op
        issue(8'h40, 8'h01, 1'b0, 8'h3F, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_D", 32'(D), 32'(0));
        check("abort_B_out", 32'(B_out), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        issue(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        wait_idle();

        // 6: start held high, one accept every WIDTH+2 cycles
        @(negedge clk);
        A = 8'h33; B = 8'h11; B_in = 1'b0; start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            if (i % 10 == 0) sb.push_back('{8'h22, 1'b0, 1'b0, cyc + int'(WIDTH) + 2});
            @(negedge clk);
            if (i >= 10 && done !== 1'b1) check("D_hold_stream", 32'(D), 32'(8'h22));
        end
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
